// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a CPU requester and a DMA requester
// Ports: cpu_* / dma_* request-side command in, rdata + one-cycle ready out;
//        mem_* drive the memory block for LAT cycles; owner shows the granted port (01 CPU, 10 DMA).
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       pick_dma;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_dma;
  // the port not served last wins a tie; a lone requester always wins
  assign pick_dma = dma_req && (!cpu_req || !last_dma);
`else
  assign pick_dma = dma_req && !cpu_req;
`endif
  // mem_we/mem_addr/mem_wdata double as the latched command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 2'b00;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma  <= 1'b1;
`endif
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        IDLE: if (cpu_req || dma_req) begin
          state     <= ACCESS;
          cnt       <= 4'(LAT);
          mem_en    <= 1'b1;
          mem_we    <= pick_dma ? dma_we : cpu_we;
          mem_addr  <= pick_dma ? dma_addr : cpu_addr;
          mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
          owner     <= pick_dma ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
          last_dma  <= pick_dma;
`endif
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= owner[0];
            dma_ready <= owner[1];
            if (!mem_we && owner[0]) cpu_rdata <= mem_rdata;
            if (!mem_we && owner[1]) dma_rdata <= mem_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic cpu_ready, dma_ready, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0] owner;
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
  bit mon_on = 1'b0;
  cmd_t cq[$], dq[$];

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h20020005;
  endfunction

  // memory model: data is only correct in the final enabled cycle, garbage before it
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc_cyc <= mem_en ? acc_cyc + 1 : 0;
  end
  assign mem_rdata = f(mem_addr) ^ ((acc_cyc == LAT - 1) ? {DW{1'b0}} : {DW{1'b1}});

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic p_en = 0, p_cready = 0, p_dready = 0, p_creq = 0, p_dreq = 0;
  logic [1:0] last_w = 2'b10, w, g_own;
  int g_cyc = 0, en_n = 0;
  cmd_t cur, pc;
  logic [DW-1:0] exp_rd[2];
  int p;
  always @(negedge clk) if (mon_on) begin
    if (mem_en) begin
      if (!p_en) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (p_creq && p_dreq) ? ((last_w == 2'b10) ? 2'b01 : 2'b10) : (p_creq ? 2'b01 : 2'b10);
`else
        w = (p_creq && p_dreq) ? 2'b01 : (p_creq ? 2'b01 : 2'b10);
`endif
        chk("grant_owner", 128'(owner), 128'(w));
        last_w = w;
        g_own = w;
        g_cyc = cyc;
        en_n = 0;
        if (w == 2'b01 && cq.size() > 0) cur = cq[0];
        else if (w == 2'b10 && dq.size() > 0) cur = dq[0];
        else begin
          checks++; errors++;
          $display("FAIL grant_pending: got grant %0b with no queued command", w);
        end
      end
      en_n++;
      chk("mem_cmd", 128'({mem_we, mem_addr, mem_wdata}), 128'(cur));
      chk("owner_hold", 128'(owner), 128'(g_own));
    end else if (p_en) chk("en_len", 128'(en_n), 128'(LAT));
    if (cpu_ready || dma_ready) begin
      chk("ready_port", 128'({dma_ready, cpu_ready}), 128'(g_own));
      chk("ready_lat", 128'(cyc - g_cyc), 128'(LAT));
      chk("ready_pulse", 128'({p_dready, p_cready}), 128'(0));
      p = dma_ready ? 1 : 0;
      if ((p == 0 && cq.size() == 0) || (p == 1 && dq.size() == 0)) begin
        checks++; errors++;
        $display("FAIL ready_pending: got ready on port %0d with empty queue", p);
      end else begin
        pc = p ? dq.pop_front() : cq.pop_front();
        if (!pc.we) exp_rd[p] = f(pc.addr);
        chk(p ? "dma_rdata" : "cpu_rdata", 128'(p ? dma_rdata : cpu_rdata), 128'(exp_rd[p]));
      end
    end
    p_en = mem_en; p_cready = cpu_ready; p_dready = dma_ready;
    p_creq = cpu_req; p_dreq = dma_req;
  end

  task automatic drive(input int port, input logic r, input cmd_t c);
    if (port == 0) begin cpu_req = r; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata; end
    else begin dma_req = r; dma_we = c.we; dma_addr = c.addr; dma_wdata = c.wdata; end
  endtask

  task automatic run_port(input int port, input int n);
    cmd_t c = '0;
    int gap, k;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drive(port, 1'b0, c);
        repeat (gap) begin @(posedge clk); #1; end
      end
      c.we = 1'($urandom_range(0, 1));
      c.addr = $urandom & 32'hFFFF_FFFC;
      c.wdata = $urandom;
      drive(port, 1'b1, c);
      if (port == 0) cq.push_back(c); else dq.push_back(c);
      k = 0;
      do begin @(posedge clk); #1; k++; end
      while (!(port == 0 ? cpu_ready : dma_ready) && k < 100);
      checks++;
      if (k >= 100) begin
        errors++;
        $display("FAIL timeout: port %0d got no ready expected within 100 cycles", port);
      end
      @(posedge clk); #1;
    end
    drive(port, 1'b0, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem", 128'({mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_ready", 128'({cpu_ready, dma_ready}), 128'(0));
    chk("rst_rdata", 128'({cpu_rdata, dma_rdata}), 128'(0));
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    mon_on = 1'b1;
    fork
      run_port(0, 60);
      run_port(1, 60);
    join
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("drain_cpu", 128'(cq.size()), 128'(0));
    chk("drain_dma", 128'(dq.size()), 128'(0));
    mon_on = 1'b0;
    // abandon a DMA read in its second access cycle
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_en", 128'(mem_en), 128'(0));
    chk("arst_owner", 128'(owner), 128'(0));
    chk("arst_ready", 128'(dma_ready), 128'(0));
    chk("arst_rdata", 128'(dma_rdata), 128'(0));
    dma_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      chk("post_en", 128'({mem_en, owner, dma_ready, cpu_ready}), 128'({1'b1, 2'b01, 2'b00}));
    end
    @(posedge clk); #1;
    chk("post_ready", 128'({cpu_ready, dma_ready, owner}), 128'({2'b10, 2'b01}));
    chk("post_rdata", 128'(cpu_rdata), 128'(f(32'h10)));
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("post_idle", 128'({cpu_ready, owner, mem_en}), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
